ssid_new_tracker: RTL

SSID_NEW_TRACKER -- requirements
Module: ssid_new_tracker

---
 rtl/ssid_new_tracker.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ssid_new_tracker.sv
// Tracks which SSIDs (HCM rows) have already been issued within an event.
// Hits are buffered, then issued one per cycle with a "first time seen" flag.
module ssid_new_tracker #(
  parameter int ROWINDEXBITS = 10,
  parameter int FIFODEPTH    = 8,
  parameter int WORDBITS     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hitValid,
  input  logic [ROWINDEXBITS-1:0] hitSSID,
  output logic                    hitReady,
  input  logic                    eventEnd,
  input  logic                    hcmBusy,
  output logic                    writeRow,
  output logic [ROWINDEXBITS-1:0] rowToWrite,
  output logic                    SSIDIsNew,
  output logic                    clearing,
  output logic [ROWINDEXBITS:0]   nNewSSIDs,
  output logic                    overflow
);

  localparam int NROWS  = 1 << ROWINDEXBITS;
  localparam int NWORDS = NROWS / WORDBITS;
  localparam int PTRW   = $clog2(FIFODEPTH);
  localparam int CNTW   = PTRW + 1;
  localparam int WIDXW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int NEWW   = ROWINDEXBITS + 1;

  localparam logic [CNTW-1:0]  FIFOFULL = CNTW'(FIFODEPTH);
  localparam logic [WIDXW-1:0] LASTWORD = WIDXW'(NWORDS - 1);
  localparam logic [NEWW-1:0]  MAXNEW   = NEWW'(NROWS);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ROWINDEXBITS-1:0] fifoMem_q [FIFODEPTH];
  logic [PTRW-1:0]         wrPtr_q, wrPtr_d;
  logic [PTRW-1:0]         rdPtr_q, rdPtr_d;
  logic [CNTW-1:0]         count_q, count_d;
  logic [NROWS-1:0]        seen_q;
  logic [WIDXW-1:0]        wordIdx_q, wordIdx_d;

  logic                    writeRow_q, writeRow_d;
  logic [ROWINDEXBITS-1:0] rowToWrite_q, rowToWrite_d;
  logic                    ssidIsNew_q, ssidIsNew_d;
  logic [NEWW-1:0]         nNew_q, nNew_d;
  logic                    overflow_q, overflow_d;

  logic                    canIssue;
  logic                    clearEn;
  logic                    push;
  logic                    fifoEmpty;
  logic                    issue;
  logic                    storePush;
  logic                    storePop;
  logic [ROWINDEXBITS-1:0] issueSSID;
  logic                    issueIsNew;
  logic                    lastWord;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (eventEnd) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = CLEAR;
      CLEAR:   if (lastWord) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    hitReady = 1'b0;
    clearing = 1'b0;
    canIssue = 1'b0;
    clearEn  = 1'b0;
    unique case (state_q)
      RUN: begin
        hitReady = (count_q < FIFOFULL);
        canIssue = !hcmBusy;
      end
      DRAIN: begin
        canIssue = !hcmBusy;
      end
      CLEAR: begin
        clearing = 1'b1;
        clearEn  = 1'b1;
      end
      default: ;
    endcase
  end

  // An empty FIFO lets an accepted hit bypass storage and issue the same cycle.
  always_comb begin
    push       = hitValid && hitReady;
    fifoEmpty  = (count_q == '0);
    issue      = canIssue && (!fifoEmpty || push);
    storePush  = push && !(fifoEmpty && issue);
    storePop   = issue && !fifoEmpty;
    issueSSID  = fifoEmpty ? hitSSID : fifoMem_q[rdPtr_q];
    issueIsNew = !seen_q[issueSSID];
    lastWord   = (wordIdx_q == LASTWORD);

    wrPtr_d = storePush ? wrPtr_q + PTRW'(1) : wrPtr_q;
    rdPtr_d = storePop  ? rdPtr_q + PTRW'(1) : rdPtr_q;
    count_d = count_q;
    if (storePush && !storePop) begin
      count_d = count_q + CNTW'(1);
    end else if (storePop && !storePush) begin
      count_d = count_q - CNTW'(1);
    end

    wordIdx_d = wordIdx_q;
    if (clearEn) begin
      wordIdx_d = lastWord ? '0 : wordIdx_q + WIDXW'(1);
    end

    writeRow_d   = issue;
    rowToWrite_d = issue ? issueSSID : rowToWrite_q;
    ssidIsNew_d  = issue ? issueIsNew : ssidIsNew_q;

    nNew_d = nNew_q;
    if (clearEn && lastWord) begin
      nNew_d = '0;
    end else if (issue && issueIsNew && (nNew_q != MAXNEW)) begin
      nNew_d = nNew_q + NEWW'(1);
    end

    overflow_d = overflow_q
               || (hitValid && !hitReady)
               || (eventEnd && (state_q != RUN));
  end

  always_ff @(posedge clk) begin
    if (storePush) begin
      fifoMem_q[wrPtr_q] <= hitSSID;
    end
  end

  // The bitmap is set on issue and wiped one word per CLEAR cycle; the two never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q <= '0;
    end else begin
      if (issue) begin
        seen_q[issueSSID] <= 1'b1;
      end
      for (int w = 0; w < NWORDS; w++) begin
        if (clearEn && (wordIdx_q == WIDXW'(w))) begin
          seen_q[w*WORDBITS +: WORDBITS] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      wordIdx_q    <= '0;
      writeRow_q   <= 1'b0;
      rowToWrite_q <= '0;
      ssidIsNew_q  <= 1'b0;
      nNew_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      wordIdx_q    <= wordIdx_d;
      writeRow_q   <= writeRow_d;
      rowToWrite_q <= rowToWrite_d;
      ssidIsNew_q  <= ssidIsNew_d;
      nNew_q       <= nNew_d;
      overflow_q   <= overflow_d;
    end
  end

  assign writeRow   = writeRow_q;
  assign rowToWrite = rowToWrite_q;
  assign SSIDIsNew  = ssidIsNew_q;
  assign nNewSSIDs  = nNew_q;
  assign overflow   = overflow_q;

endmodule
